button_pio_debounced: RTL and testbench

BUTTON_PIO_DEBOUNCED -- requirements
Module: button_pio_debounced

---
 rtl/button_pio_debounced_if.sv | 19 +
 rtl/button_pio_debounced.sv | 119 +++++++++++
 tb/tb_button_pio_debounced.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/button_pio_debounced_if.sv
// Avalon-MM slave bus and interrupt line for the debounced button PIO.
interface button_pio_debounced_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/button_pio_debounced.sv
// Debounced button PIO: 2-flop synchronizer, per-bit debounce counter,
// edge capture with write-1-to-clear, interrupt mask and registered reads.
// Register map: 0 stable (RO), 1 synchronized raw input (RO),
// 2 irqmask (RW), 3 edgecapture (R, W1C).
module button_pio_debounced #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  button_pio_debounced_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]          sync1_q, sync2_q;
  logic [WIDTH-1:0]          stable_q, stable_d;
  logic [WIDTH-1:0]          stable_dly_q;
  logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]          irqmask_q, irqmask_d;
  logic [WIDTH-1:0]          edgecap_q, edgecap_d;
  logic [WIDTH-1:0]          edge_sel;
  logic [WIDTH-1:0]          clr_mask;
  logic [31:0]               readdata_q, readdata_d;
  logic                      wr_en;

  assign wr_en = bus.chipselect && !bus.write_n;

  // Two-flop synchronizer on the raw button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive mismatch cycles, accept the new
  // level on the cycle the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state and delayed copy of stable for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Edge selection; a change on stable is seen here for exactly one cycle.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_sel = stable_q & ~stable_dly_q;
      1:       edge_sel = ~stable_q & stable_dly_q;
      default: edge_sel = stable_q ^ stable_dly_q;
    endcase
  end

  // Register writes: mask load, and W1C where a new edge wins over the clear.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && bus.address == 2'd2) irqmask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == 2'd3) clr_mask  = bus.writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | edge_sel;
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    case (bus.address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(sync2_q);
      2'd2:    readdata_d = 32'(irqmask_q);
      default: readdata_d = 32'(edgecap_q);
    endcase
  end

  // Control/status registers and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Scoreboard bench for button_pio_debounced (WIDTH=2, DEBOUNCE_CYCLES=4,
// falling-edge capture). Stimulus pushes expectations; the monitor pops and
// compares one cycle after each request is presented.
module tb_button_pio_debounced;
  localparam int W = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;

  button_pio_debounced_if bus();

  button_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic        req_v = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic        fire;
  logic [32:0] exp_item;
  string       exp_name;
  logic [31:0] got;

  // Request a check: readdata of address a, or irq, observed one cycle later.
  task automatic chk(input bit is_irq, input logic [1:0] a, input logic [31:0] e,
                     input string nm);
    if (!is_irq) bus.address = a;
    exp_q.push_back({is_irq, e});
    name_q.push_back(nm);
    req_v = 1'b1;
    @(negedge clk);
    req_v = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit cs = 1'b1);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a request seen at a rising edge is compared at the next falling edge.
  initial begin
    forever begin
      @(posedge clk);
      fire = req_v;
      @(negedge clk);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL monitor: request with empty scoreboard");
        end else begin
          exp_item = exp_q.pop_front();
          exp_name = name_q.pop_front();
          got = exp_item[32] ? {31'b0, bus.irq} : bus.readdata;
          if (got !== exp_item[31:0]) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", exp_name, got, exp_item[31:0]);
          end
        end
      end
    end
  end

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    idle(3);
    reset_n = 1'b1;

    // Post-reset state.
    chk(0, 2'd0, 32'h0, "rst_stable");
    chk(0, 2'd1, 32'h0, "rst_sync");
    chk(0, 2'd2, 32'h0, "rst_mask");
    chk(0, 2'd3, 32'h0, "rst_edgecap");
    chk(1, 2'd0, 32'h0, "rst_irq");
    idle(2);

    // in_port 00->01: stable[0] rises 6 edges later, visible on the 7th read.
    for (int i = 1; i <= 7; i++) begin
      if (i == 1) in_port = 2'b01;
      chk(0, 2'd0, (i >= 7) ? 32'h1 : 32'h0, $sformatf("rise_delay_%0d", i));
    end
    idle(3);

    // 3-cycle glitch on bit 1: sync readback shows it 2 cycles late, stable unchanged.
    for (int i = 0; i <= 6; i++) begin
      in_port = (i < 3) ? 2'b11 : 2'b01;
      chk(0, 2'd1, (i >= 2 && i <= 4) ? 32'h3 : 32'h1, $sformatf("glitch_sync_%0d", i));
    end
    idle(8);
    chk(0, 2'd0, 32'h1, "glitch_stable");

    // Falling edge on bit 0 with mask=1: irq rises one cycle after stable falls.
    wr(2'd2, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) in_port = 2'b00;
      chk(1, 2'd0, (i >= 7) ? 32'h1 : 32'h0, $sformatf("fall_irq_%0d", i));
    end
    chk(0, 2'd3, 32'h1, "fall_edgecap");
    wr(2'd3, 32'h1);
    chk(1, 2'd0, 32'h0, "w1c_irq");
    chk(0, 2'd3, 32'h0, "w1c_edgecap");

    // Mask behaviour with edgecapture=0x3.
    wr(2'd2, 32'h0);
    in_port = 2'b11;
    idle(10);
    in_port = 2'b00;
    idle(10);
    chk(1, 2'd0, 32'h0, "masked_irq");
    chk(0, 2'd3, 32'h3, "both_edgecap");
    wr(2'd0, 32'h3);
    chk(0, 2'd0, 32'h0, "ro_addr0");
    wr(2'd2, 32'h3, 1'b0);
    chk(1, 2'd0, 32'h0, "no_cs_irq");
    chk(0, 2'd2, 32'h0, "no_cs_mask");
    wr(2'd2, 32'h2);
    chk(1, 2'd0, 32'h1, "mask2_irq");
    wr(2'd2, 32'hFFFF_FFFC);
    chk(0, 2'd2, 32'h0, "mask_hi_bits");
    chk(1, 2'd0, 32'h0, "mask_hi_irq");
    wr(2'd3, 32'h3);
    chk(0, 2'd3, 32'h0, "clear_both");

    // New edge on bit 0 in the same cycle as its W1C: set wins.
    in_port = 2'b01;
    idle(10);
    in_port = 2'b00;
    idle(6);
    wr(2'd3, 32'h1);
    chk(0, 2'd3, 32'h1, "set_priority");
    wr(2'd3, 32'h1);
    chk(0, 2'd3, 32'h0, "set_priority_clr");

    // Reset mid-debounce (counter at 2): full delay restarts after release.
    wr(2'd2, 32'h3);
    idle(10);
    in_port = 2'b01;
    idle(4);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      chk(0, 2'd0, (i >= 7) ? 32'h1 : 32'h0, $sformatf("rst_restart_%0d", i));
    end
    chk(0, 2'd2, 32'h0, "rst_mid_mask");
    chk(0, 2'd3, 32'h0, "rst_mid_edgecap");
    chk(1, 2'd0, 32'h0, "rst_mid_irq");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
